// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key event decoder: resolves E0/F0/E1 prefixes, tracks modifiers, queues makes in a FWFT FIFO.
// Optional caps-lock tracking is enabled by defining KBD_CAPS_EN.
module ps2_key_decoder #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  input  logic       key_rd,
  output logic       key_valid,
  output logic [7:0] key_sc,
  output logic       key_extend,
  output logic       key_shift,
  output logic       key_ctrl,
  output logic       key_alt,
  output logic       overflow
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DepthCnt = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0]   CntOne   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PtrOne   = FIFO_AW'(1);

  // {ext, scancode} keys for the modifier table
  localparam logic [8:0] KeyLshift = 9'h012;
  localparam logic [8:0] KeyRshift = 9'h059;
  localparam logic [8:0] KeyLctrl  = 9'h014;
  localparam logic [8:0] KeyLalt   = 9'h011;
  localparam logic [8:0] KeyRctrl  = 9'h114;
  localparam logic [8:0] KeyRalt   = 9'h111;
  localparam logic [8:0] KeyFakeL  = 9'h112;
  localparam logic [8:0] KeyFakeR  = 9'h159;

  localparam int unsigned ModLshift = 0;
  localparam int unsigned ModRshift = 1;
  localparam int unsigned ModLctrl  = 2;
  localparam int unsigned ModRctrl  = 3;
  localparam int unsigned ModLalt   = 4;
  localparam int unsigned ModRalt   = 5;

  typedef enum logic [2:0] {StIdle, StE0, StF0, StE0F0, StSkip} state_e;

  state_e      state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [5:0]  mod_q, mod_d;
  logic        push_q, push_d;
  logic [11:0] entry_q, entry_d;
  logic        overflow_q, overflow_d;
  logic        mk, brk, ext, shift_snap;
`ifdef KBD_CAPS_EN
  logic        caps_q, caps_d;

  function automatic logic is_letter(input logic [7:0] sc);
    case (sc)
      8'h15, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h21, 8'h22, 8'h23, 8'h24, 8'h2A, 8'h2B, 8'h2C, 8'h2D,
      8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h3A, 8'h3B, 8'h3C, 8'h42, 8'h43, 8'h44, 8'h4B,
      8'h4D:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    mod_d   = mod_q;
    push_d  = 1'b0;
    entry_d = entry_q;
    mk      = 1'b0;
    brk     = 1'b0;
    ext     = 1'b0;
    shift_snap = mod_q[ModLshift] | mod_q[ModRshift];
`ifdef KBD_CAPS_EN
    caps_d = caps_q;
    if (is_letter(rx_data)) shift_snap = shift_snap ^ caps_q;
`endif
    if (rx_err) begin
      state_d = StIdle;
      skip_d  = '0;
    end else if (rx_valid) begin
      case (state_q)
        StIdle: begin
          case (rx_data)
            8'hE0: state_d = StE0;
            8'hF0: state_d = StF0;
            8'hE1: begin
              state_d = StSkip;
              skip_d  = 3'd7;
            end
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_d = StIdle;
            default: mk = 1'b1;
          endcase
        end
        StE0: begin
          if (rx_data == 8'hF0) begin
            state_d = StE0F0;
          end else begin
            state_d = StIdle;
            mk      = 1'b1;
            ext     = 1'b1;
          end
        end
        StF0: begin
          state_d = StIdle;
          brk     = 1'b1;
        end
        StE0F0: begin
          state_d = StIdle;
          brk     = 1'b1;
          ext     = 1'b1;
        end
        StSkip: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (mk || brk) begin
      case ({ext, rx_data})
        KeyLshift: mod_d[ModLshift] = mk;
        KeyRshift: mod_d[ModRshift] = mk;
        KeyLctrl:  mod_d[ModLctrl]  = mk;
        KeyRctrl:  mod_d[ModRctrl]  = mk;
        KeyLalt:   mod_d[ModLalt]   = mk;
        KeyRalt:   mod_d[ModRalt]   = mk;
        KeyFakeL, KeyFakeR: begin
        end
        default: begin
          if (mk) begin
            push_d  = 1'b1;
            entry_d = {rx_data, ext, shift_snap, mod_q[ModLctrl] | mod_q[ModRctrl],
                       mod_q[ModLalt] | mod_q[ModRalt]};
`ifdef KBD_CAPS_EN
            if (!ext && rx_data == 8'h58) caps_d = ~caps_q;
`endif
          end
        end
      endcase
    end
  end

  // FIFO bookkeeping; the registered event is written one cycle after its byte
  logic [11:0]        mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               do_push, do_pop, full;

  always_comb begin
    full       = (count_q == DepthCnt);
    do_pop     = key_rd && (count_q != '0);
    do_push    = push_q && (!full || do_pop);
    overflow_d = push_q && full && !do_pop;
    count_d    = count_q;
    if (do_push && !do_pop) count_d = count_q + CntOne;
    else if (do_pop && !do_push) count_d = count_q - CntOne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      skip_q     <= '0;
      mod_q      <= '0;
      push_q     <= 1'b0;
      entry_q    <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef KBD_CAPS_EN
      caps_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      mod_q      <= mod_d;
      push_q     <= push_d;
      entry_q    <= entry_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrOne;
`ifdef KBD_CAPS_EN
      caps_q     <= caps_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= entry_q;
  end

  assign key_valid = (count_q != '0);
  assign overflow  = overflow_q;
  // Gate the head so outputs read zero while empty (memory itself is not reset)
  assign {key_sc, key_extend, key_shift, key_ctrl, key_alt} =
      key_valid ? mem[rd_ptr_q] : 12'h000;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder (FIFO_AW = 3).
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, key_rd;
  logic       key_valid, key_extend, key_shift, key_ctrl, key_alt, overflow;
  logic [7:0] key_sc;

  int n_cmp = 0;
  int n_bad = 0;
  int ovf_cnt = 0;

  ps2_key_decoder #(.FIFO_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .key_rd(key_rd), .key_valid(key_valid), .key_sc(key_sc), .key_extend(key_extend),
    .key_shift(key_shift), .key_ctrl(key_ctrl), .key_alt(key_alt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All stimulus is applied at negedges; each byte occupies one cycle
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_expect(input string tag, input logic [11:0] exp);
    check_eq({tag, "_valid"}, {31'd0, key_valid}, 32'd1);
    check_eq({tag, "_head"}, {20'd0, key_sc, key_extend, key_shift, key_ctrl, key_alt},
             {20'd0, exp});
    key_rd = 1'b1;
    @(negedge clk);
    key_rd = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (key_valid !== 1'b1) break;
      key_rd = 1'b1;
      @(negedge clk);
      key_rd = 1'b0;
      n++;
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0; key_rd = 1'b0;
    tick(3);
    check_eq("rst_valid", {31'd0, key_valid}, 32'd0);
    check_eq("rst_head", {20'd0, key_sc, key_extend, key_shift, key_ctrl, key_alt}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Make then break: one entry, latency of two edges
    send(8'h1C);
    check_eq("lat_n", {31'd0, key_valid}, 32'd0);
    tick(1);
    check_eq("lat_n1", {31'd0, key_valid}, 32'd1);
    send(8'hF0); send(8'h1C); tick(2);
    pop_expect("mk1c", {8'h1C, 4'b0000});
    check_eq("brk_notq", {31'd0, key_valid}, 32'd0);

    // Shift snapshot
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C); tick(2);
    pop_expect("sh1", {8'h1C, 4'b0100});
    pop_expect("sh0", {8'h1C, 4'b0000});
    check_eq("sh_empty", {31'd0, key_valid}, 32'd0);

    // Extended keys, right ctrl / right alt, fake shift ignored
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h14); send(8'h21);
    send(8'hE0); send(8'h11); send(8'hE0); send(8'h12); send(8'h1C); tick(2);
    pop_expect("ext75", {8'h75, 4'b1000});
    pop_expect("rctl21", {8'h21, 4'b0010});
    pop_expect("ralt1c", {8'h1C, 4'b0011});
    send(8'hE0); send(8'hF0); send(8'h14); send(8'hE0); send(8'hF0); send(8'h11); tick(2);
    check_eq("ext_empty", {31'd0, key_valid}, 32'd0);

    // Pause sequence and discarded bytes
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14);
    send(8'hF0); send(8'h77); send(8'hFA); send(8'hAA); tick(2);
    check_eq("pause_empty", {31'd0, key_valid}, 32'd0);
    send(8'h1C); tick(2);
    pop_expect("post_pause", {8'h1C, 4'b0000});

    // rx_err resets prefix, keeps modifiers; coincident byte dropped
    send(8'h12); send(8'hE0);
    rx_err = 1'b1; @(negedge clk); rx_err = 1'b0;
    send(8'h75); tick(2);
    pop_expect("err_mod", {8'h75, 4'b0100});
    rx_data = 8'h1C; rx_valid = 1'b1; rx_err = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_err = 1'b0;
    tick(2);
    check_eq("err_drop", {31'd0, key_valid}, 32'd0);
    send(8'hF0); send(8'h12); tick(1);

    // Overflow without pop
    for (int i = 0; i < 9; i++) send(8'h1C);
    tick(3);
    check_eq("ovf_once", ovf_cnt, 32'd1);
    drain(n);
    check_eq("ovf_cnt8", n, 32'd8);

    // Ninth push with coincident pop
    for (int i = 0; i < 8; i++) send(8'h1C);
    tick(2);
    rx_data = 8'h1C; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; key_rd = 1'b1;
    @(negedge clk);
    key_rd = 1'b0;
    tick(2);
    check_eq("rdpush_noovf", ovf_cnt, 32'd1);
    drain(n);
    check_eq("rdpush_cnt8", n, 32'd8);

    // Caps lock
    send(8'h58); send(8'h1C); send(8'h12); send(8'h1C); tick(2);
    pop_expect("caps58", {8'h58, 4'b0000});
`ifdef KBD_CAPS_EN
    pop_expect("caps_a", {8'h1C, 4'b0100});
    pop_expect("caps_b", {8'h1C, 4'b0000});
`else
    pop_expect("caps_a", {8'h1C, 4'b0000});
    pop_expect("caps_b", {8'h1C, 4'b0100});
`endif

    // Reset mid-sequence discards FIFO and modifiers
    send(8'h1C); send(8'hE0); tick(2);
    rst_n = 1'b0; tick(1);
    check_eq("rst_mid", {31'd0, key_valid}, 32'd0);
    rst_n = 1'b1; tick(1);
    send(8'h75); tick(2);
    pop_expect("after_rst", {8'h75, 4'b0000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
